dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- Decoupling FIFO between the decoder and the rename/dispatch stage (RAT, FreeList, ROB, RS).
- Buffers decoded bundles with their architectural register indices and epoch tag.
- Presents the head entry first-word-fall-through as alloc_valid, decoded_bundle_fields, rs1_arch, rs2_arch and alloc_rd_arch; the dispatch stage's alloc_ready is the pop handshake.
- Drops stale-epoch arrivals on enqueue and clears completely on flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- EPOCH_W, package value, epoch tag width.
- PTR_W, $clog2(DEPTH), read/write pointer width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  decoder offers an entry.
- in_ready  output  1  queue accepts the offered entry this cycle.
- in_bundle  input  decoded_bundle_t  decoded fields.
- in_rs1_arch  input  5  source 1 architectural register.
- in_rs2_arch  input  5  source 2 architectural register.
- in_rd_arch  input  5  destination architectural register.
- in_epoch  input  EPOCH_W  epoch the entry was fetched under.
- cur_epoch  input  EPOCH_W  current front-end epoch.
- out_valid  output  1  head entry valid; drives alloc_valid.
- out_ready  input  1  dispatch consumes the head; driven from alloc_ready.
- out_bundle  output  decoded_bundle_t  head decoded fields.
- out_rs1_arch, out_rs2_arch, out_rd_arch  output  5 each  head register indices.
- out_epoch  output  EPOCH_W  head epoch; drives alloc_epoch.
- flush_valid  input  1  pipeline flush.
- count  output  CNT_W  occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop_cnt  output  16  saturating count of stale entries dropped.

Behaviour:
- Reset (synchronous, rst=1): head, tail and count go to 0; drop_cnt goes to 0; storage contents don't matter.
  - While rst is high: out_valid=0, in_ready=0, empty=1, full=0.
  - rst takes priority over flush and all handshakes. A reset mid-stream discards every entry.
- Handshakes:
  - in_ready = !full && !flush_valid && !rst.
  - Push fires when in_valid && in_ready.
  - out_valid = !empty && !flush_valid.
  - Pop fires when out_valid && out_ready.
  - in_valid and its data are held by the producer until in_ready. The queue never withdraws out_valid except on flush or reset.
- Enqueue filter: a firing push with in_epoch != cur_epoch is consumed but not written.
  - tail and count do not move.
  - drop_cnt increments and saturates at 16'hFFFF.
- Storage and pointers:
  - A valid push writes {in_bundle, arch indices, in_epoch} at tail; tail becomes tail+1 modulo DEPTH.
  - A pop advances head modulo DEPTH. Wrap is a natural PTR_W overflow.
- Count update: count_next = count + push_written - pop. A simultaneous write and pop leaves count unchanged, including when full (no push when full) and when empty (no pop when empty).
- Latency: no empty bypass. An entry written at edge N is visible on out_* after edge N, i.e. in cycle N+1. Minimum end-to-end latency is 1 cycle.
- Output data: out_* is a combinational read of storage at head. It is don't-care when out_valid=0 and must be stable while out_valid=1 and out_ready=0.
- Flush (flush_valid=1 for any number of cycles):
  - Every cycle with flush_valid: head=tail=0, count=0, no push, no pop.
  - drop_cnt is unaffected.
  - First push after flush deasserts is accepted in the following cycle.
- Boundaries:
  - Full: in_ready=0. A pop on that cycle frees a slot for the next cycle, not the same cycle.
  - Empty: out_valid=0 regardless of out_ready.
  - cur_epoch changing while entries are queued does not affect them; the flush clears them.

Decomposition:
- Shared package (with the existing defines):
  - dq_entry_t packed struct {decoded_bundle_t bundle; logic [4:0] rs1, rs2, rd; logic [EPOCH_W-1:0] epoch}.
  - EPOCH_W and the default DEPTH constant.
- No sub-module required. Storage is an array of dq_entry_t inside the block.
- Top-level wiring connects out_valid to alloc_valid and alloc_ready to out_ready.

Test Plan:
- Reset then 3 pushes (epoch=cur_epoch=2) with out_ready=0: count=3, out_rs1_arch equals the first entry's rs1, in_ready=1. Raise out_ready for 3 cycles: entries leave in order, empty=1.
- DEPTH=8, 8 pushes with no pops: full=1, in_ready=0, and a 9th in_valid held 2 cycles is not accepted. Pop once: in_ready=1 next cycle and the 9th entry is written, count=8.
- Fill to 4, then push and pop together for 20 cycles: count stays 4 throughout, pointers wrap, and output order matches input order exactly.
- cur_epoch=3, push entries with in_epoch 3,2,3,2: count=2, drop_cnt=2, and the outputs are only the two epoch-3 entries.
- Fill to 5, assert flush_valid alongside in_valid and out_ready: out_valid=0, in_ready=0, next cycle count=0 and empty=1, and a push after flush deasserts appears 1 cycle later.
- Fill to 6, assert rst for 1 cycle during a push/pop: count=0, drop_cnt=0, out_valid=0, and in_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/dispatch_queue_pkg.sv
// Shared types for the decoder-to-dispatch queue.
// Entry layout is what dispatch reads at the queue head.
package dispatch_queue_pkg;

   localparam int EPOCH_W  = 2;
   localparam int DQ_DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
   } decoded_bundle_t;

   typedef struct packed {
      decoded_bundle_t      bundle;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [4:0]           rd;
      logic [EPOCH_W-1:0]   epoch;
   } dq_entry_t;

endpackage

// File: rtl/dispatch_queue.sv
// Decoder-to-rename FIFO, first-word-fall-through head.
// Stale-epoch arrivals are consumed and counted, never stored.
module dispatch_queue
   import dispatch_queue_pkg::*;
#(
   parameter int DEPTH = DQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  decoded_bundle_t      in_bundle,
   input  logic [4:0]           in_rs1_arch,
   input  logic [4:0]           in_rs2_arch,
   input  logic [4:0]           in_rd_arch,
   input  logic [EPOCH_W-1:0]   in_epoch,
   input  logic [EPOCH_W-1:0]   cur_epoch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output decoded_bundle_t      out_bundle,
   output logic [4:0]           out_rs1_arch,
   output logic [4:0]           out_rs2_arch,
   output logic [4:0]           out_rd_arch,
   output logic [EPOCH_W-1:0]   out_epoch,
   input  logic                 flush_valid,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty,
   output logic [15:0]          drop_cnt
);

   dq_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [15:0]        drop_q, drop_d;
   logic               push, pop, stale, wr;
   dq_entry_t          wr_entry;
   dq_entry_t          head_entry;

   assign full      = !rst && (count_q == CNT_W'(DEPTH));
   assign empty     = rst || (count_q == '0);
   assign in_ready  = !full && !flush_valid && !rst;
   assign out_valid = !empty && !flush_valid;

   assign push  = in_valid && in_ready;
   assign pop   = out_valid && out_ready;
   assign stale = (in_epoch != cur_epoch);
   assign wr    = push && !stale;

   assign wr_entry = '{bundle: in_bundle, rs1: in_rs1_arch,
                       rs2: in_rs2_arch, rd: in_rd_arch,
                       epoch: in_epoch};

   assign head_entry   = mem_q[head_q];
   assign out_bundle   = head_entry.bundle;
   assign out_rs1_arch = head_entry.rs1;
   assign out_rs2_arch = head_entry.rs2;
   assign out_rd_arch  = head_entry.rd;
   assign out_epoch    = head_entry.epoch;

   assign count    = count_q;
   assign drop_cnt = drop_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      drop_d  = drop_q;
      if (flush_valid) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wr) tail_d = tail_q + PTR_W'(1);
         if (pop) head_d = head_q + PTR_W'(1);
         case ({wr, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         // a stale push is still consumed so the decoder moves on
         if (push && stale && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[tail_q] <= wr_entry;
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with a small queue model.
// Constant checks cover the hand-computed test-plan points.
module tb_dispatch_queue;
   import dispatch_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   decoded_bundle_t      in_bundle;
   logic [4:0]           in_rs1_arch, in_rs2_arch, in_rd_arch;
   logic [EPOCH_W-1:0]   in_epoch, cur_epoch;
   logic                 out_valid;
   logic                 out_ready;
   decoded_bundle_t      out_bundle;
   logic [4:0]           out_rs1_arch, out_rs2_arch, out_rd_arch;
   logic [EPOCH_W-1:0]   out_epoch;
   logic                 flush_valid;
   logic [CNT_W-1:0]     count;
   logic                 full, empty;
   logic [15:0]          drop_cnt;

   dispatch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_bundle(in_bundle),
      .in_rs1_arch(in_rs1_arch), .in_rs2_arch(in_rs2_arch),
      .in_rd_arch(in_rd_arch),
      .in_epoch(in_epoch), .cur_epoch(cur_epoch),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_bundle(out_bundle),
      .out_rs1_arch(out_rs1_arch), .out_rs2_arch(out_rs2_arch),
      .out_rd_arch(out_rd_arch), .out_epoch(out_epoch),
      .flush_valid(flush_valid),
      .count(count), .full(full), .empty(empty),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   dq_entry_t  mq[$];
   int         m_drops = 0;
   int         nxt = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_data(input int k);
      in_bundle.pc     = 32'h100 + 32'(k * 4);
      in_bundle.opcode = 7'(k * 5 + 3);
      in_bundle.funct3 = 3'(k);
      in_rs1_arch      = 5'(k + 1);
      in_rs2_arch      = 5'(k * 2);
      in_rd_arch       = 5'(31 - k);
   endtask

   function automatic dq_entry_t cur_entry();
      dq_entry_t e;
      e.bundle = in_bundle;
      e.rs1    = in_rs1_arch;
      e.rs2    = in_rs2_arch;
      e.rd     = in_rd_arch;
      e.epoch  = in_epoch;
      return e;
   endfunction

   function automatic dq_entry_t out_entry();
      dq_entry_t e;
      e.bundle = out_bundle;
      e.rs1    = out_rs1_arch;
      e.rs2    = out_rs2_arch;
      e.rd     = out_rd_arch;
      e.epoch  = out_epoch;
      return e;
   endfunction

   // One clock: check handshakes, advance model, check state.
   task automatic tick();
      logic e_ir, e_ov, acc, pp;
      #1;
      e_ir = !rst && !flush_valid && (mq.size() < DEPTH);
      e_ov = !rst && !flush_valid && (mq.size() > 0);
      check("in_ready", 64'(in_ready), 64'(e_ir));
      check("out_valid", 64'(out_valid), 64'(e_ov));
      if (e_ov) check("head", 64'(out_entry()), 64'(mq[0]));
      acc = in_valid && e_ir;
      pp  = out_ready && e_ov;
      if (rst) begin
         mq.delete();
         m_drops = 0;
      end else if (flush_valid) begin
         mq.delete();
      end else begin
         if (pp) void'(mq.pop_front());
         if (acc) begin
            if (in_epoch == cur_epoch) mq.push_back(cur_entry());
            else if (m_drops < 16'hFFFF) m_drops++;
         end
      end
      @(posedge clk);
      #1;
      check("count", 64'(count), 64'(mq.size()));
      check("empty", 64'(empty), 64'(mq.size() == 0));
      check("full", 64'(full), 64'(mq.size() == DEPTH));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      if (acc) begin
         nxt++;
         set_data(nxt);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      flush_valid = 1'b0; cur_epoch = 2'd2; in_epoch = 2'd2;
      set_data(0);
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      tick();
      rst = 1'b0;

      // three pushes, then drain in order
      in_valid = 1'b1;
      run(3);
      in_valid = 1'b0;
      #1;
      check("t1_count", 64'(count), 64'd3);
      check("t1_rs1", 64'(out_rs1_arch), 64'd1);
      check("t1_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      run(3);
      check("t1_empty", 64'(empty), 64'd1);

      // fill to full, hold a 9th, pop once
      out_ready = 1'b0;
      in_valid = 1'b1;
      run(8);
      check("t2_full", 64'(full), 64'd1);
      check("t2_in_ready", 64'(in_ready), 64'd0);
      run(2);
      check("t2_held", 64'(count), 64'd8);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      check("t2_count8", 64'(count), 64'd8);
      in_valid = 1'b0;
      out_ready = 1'b1;
      run(8);

      // steady push/pop at occupancy 4 across wrap
      out_ready = 1'b0;
      in_valid = 1'b1;
      run(4);
      out_ready = 1'b1;
      run(20);
      check("t3_count4", 64'(count), 64'd4);
      in_valid = 1'b0;
      run(4);

      // stale-epoch filter
      out_ready = 1'b0;
      cur_epoch = 2'd3;
      in_valid = 1'b1;
      in_epoch = 2'd3; tick();
      in_epoch = 2'd2; tick();
      in_epoch = 2'd3; tick();
      in_epoch = 2'd2; tick();
      in_valid = 1'b0;
      check("t4_count", 64'(count), 64'd2);
      check("t4_drop", 64'(drop_cnt), 64'd2);
      check("t4_epoch", 64'(out_epoch), 64'd3);
      out_ready = 1'b1;
      run(2);

      // flush with push and pop offered
      in_epoch = 2'd3;
      out_ready = 1'b0;
      in_valid = 1'b1;
      run(5);
      flush_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      check("t5_count", 64'(count), 64'd0);
      check("t5_drop", 64'(drop_cnt), 64'd2);
      flush_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      check("t5_post_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      run(1);

      // reset mid-stream
      out_ready = 1'b0;
      in_valid = 1'b1;
      run(6);
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("t6_rst_empty", 64'(empty), 64'd1);
      check("t6_rst_full", 64'(full), 64'd0);
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      check("t6_count", 64'(count), 64'd0);
      check("t6_drop", 64'(drop_cnt), 64'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
